// File: rtl/llsc_mem_ctrl.sv
// MEM-stage LL/SC sequencer: issues the LL load or SC store on the data bus, tracks the
// link address against snooped stores and produces the rt writeback and LLbit update.
module llsc_mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_valid,
    input  logic              op_ll,
    input  logic              op_sc,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic              llbit_i,
    input  logic              wb_llbit_we,
    input  logic              wb_llbit_val,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              llbit_we_o,
    output logic              llbit_o
);

    typedef enum logic [1:0] {StIdle, StLlReq, StScReq, StResp} state_e;

    state_e              r_state;
    logic                r_link_valid;
    logic [ADDR_W-1:2]   r_link_addr;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_result;
    logic                r_done;
    logic                r_llbit_we;
    logic                r_llbit;

    logic                w_eff_llbit;
    logic                w_sc_ok;
    logic                w_snoop_hit;
    logic [ADDR_W-1:0]   w_word_addr;

    // A pending WB write to LLbit is newer than the register value.
    assign w_eff_llbit = wb_llbit_we ? wb_llbit_val : llbit_i;
    assign w_sc_ok     = w_eff_llbit & r_link_valid & (r_link_addr == op_addr[ADDR_W-1:2]);
    assign w_snoop_hit = snoop_we & r_link_valid & (r_link_addr == snoop_addr[ADDR_W-1:2]);
    assign w_word_addr = {op_addr[ADDR_W-1:2], 2'b00};

    assign stall_o = (r_state == StLlReq) | (r_state == StScReq) |
                     ((r_state == StIdle) & op_valid);

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign done_o     = r_done;
    assign result_o   = r_result;
    assign llbit_we_o = r_llbit_we;
    assign llbit_o    = r_llbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_result     <= '0;
            r_done       <= 1'b0;
            r_llbit_we   <= 1'b0;
            r_llbit      <= 1'b0;
        end else if (flush) begin
            // An ack landing here is treated as performed; its data is simply dropped.
            r_state      <= StIdle;
            r_mem_req    <= 1'b0;
            r_link_valid <= 1'b0;
            r_done       <= 1'b0;
            r_llbit_we   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_llbit_we <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_snoop_hit) begin
                        r_link_valid <= 1'b0;
                    end
                    if (op_valid && op_ll) begin
                        r_state    <= StLlReq;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_word_addr;
                    end else if (op_valid && op_sc) begin
                        if (w_sc_ok) begin
                            r_state     <= StScReq;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= op_wdata;
                        end else begin
                            r_state  <= StResp;
                            r_result <= '0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                StLlReq: begin
                    if (w_snoop_hit) begin
                        r_link_valid <= 1'b0;
                    end
                    // Link set on ack overrides a coincident snoop clear.
                    if (mem_ack) begin
                        r_state      <= StResp;
                        r_mem_req    <= 1'b0;
                        r_result     <= mem_rdata;
                        r_done       <= 1'b1;
                        r_llbit_we   <= 1'b1;
                        r_llbit      <= 1'b1;
                        r_link_addr  <= r_mem_addr[ADDR_W-1:2];
                        r_link_valid <= 1'b1;
                    end
                end
                StScReq: begin
                    if (mem_ack) begin
                        r_state      <= StResp;
                        r_mem_req    <= 1'b0;
                        r_result     <= DATA_W'(1);
                        r_done       <= 1'b1;
                        r_llbit_we   <= 1'b1;
                        r_llbit      <= 1'b0;
                        r_link_valid <= 1'b0;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// Scoreboard bench for llsc_mem_ctrl: expected bus transfers and completions are queued at
// issue; a bus responder and a completion monitor pop and compare independently.
module tb_llsc_mem_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [31:0] res;
        logic        we;
        logic        lb;
    } done_t;

    logic        clk = 1'b0;
    logic        rst, flush, op_valid, op_ll, op_sc;
    logic [31:0] op_addr, op_wdata;
    logic        llbit_i, wb_llbit_we, wb_llbit_val;
    logic        snoop_we;
    logic [31:0] snoop_addr;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_o, done_o, llbit_we_o, llbit_o;
    logic [31:0] result_o;

    logic        snp_we_man = 1'b0;
    logic [31:0] snp_addr_man = '0;
    logic        snp_we_ack = 1'b0;
    logic [31:0] snp_addr_ack = '0;
    logic        snoop_at_ack = 1'b0;
    logic [31:0] snoop_ack_addr = '0;

    int          lat_v = 1;
    logic [31:0] rdata_v = '0;
    int          cnt = 0;
    int          checks = 0;
    int          failures = 0;

    bus_t        exp_bus[$];
    done_t       exp_done[$];

    assign snoop_we   = snp_we_man | snp_we_ack;
    assign snoop_addr = snp_we_ack ? snp_addr_ack : snp_addr_man;

    always #5 clk = ~clk;

    llsc_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .op_valid(op_valid), .op_ll(op_ll), .op_sc(op_sc),
        .op_addr(op_addr), .op_wdata(op_wdata),
        .llbit_i(llbit_i), .wb_llbit_we(wb_llbit_we), .wb_llbit_val(wb_llbit_val),
        .snoop_we(snoop_we), .snoop_addr(snoop_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o),
        .llbit_we_o(llbit_we_o), .llbit_o(llbit_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus responder: acks after lat_v cycles of mem_req and checks the transfer.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack    = 1'b0;
            snp_we_ack = 1'b0;
        end else if (mem_req) begin
            if (cnt == 0) begin
                checks++;
                if (exp_bus.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_bus_req: got addr 0x%0h expected no request",
                             mem_addr);
                end
            end
            cnt++;
            if (cnt >= lat_v && exp_bus.size() != 0) begin
                bus_t e;
                e = exp_bus.pop_front();
                chk("bus_addr", 64'(mem_addr), 64'(e.addr));
                chk("bus_we", 64'(mem_we), 64'(e.we));
                if (e.we) chk("bus_wdata", 64'(mem_wdata), 64'(e.wdata));
                mem_rdata = rdata_v;
                mem_ack   = 1'b1;
                cnt       = 0;
                if (snoop_at_ack) begin
                    snp_we_ack   = 1'b1;
                    snp_addr_ack = snoop_ack_addr;
                    snoop_at_ack = 1'b0;
                end
            end
        end else begin
            cnt = 0;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (done_o) begin
            if (exp_done.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done_o=1 expected 0 at %0t", $time);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                chk("result", 64'(result_o), 64'(d.res));
                chk("llbit_we", 64'(llbit_we_o), 64'(d.we));
                if (d.we) chk("llbit_val", 64'(llbit_o), 64'(d.lb));
            end
        end
    end

    task automatic start_op(input bit ll, input bit sc, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                            input bit bus_on);
        @(negedge clk);
        lat_v   = lat;
        rdata_v = rdata;
        if (bus_on) exp_bus.push_back('{addr & 32'hFFFF_FFFC, !ll, wdata});
        op_ll    = ll;
        op_sc    = sc;
        op_addr  = addr;
        op_wdata = wdata;
        op_valid = 1'b1;
    endtask

    task automatic do_op(input string name, input bit ll, input bit sc, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                         input logic [31:0] exp_res, input bit exp_we, input bit exp_lb,
                         input bit bus_on, input int exp_cyc);
        int stalls;
        int cyc;
        bit seen;
        exp_done.push_back('{exp_res, exp_we, exp_lb});
        start_op(ll, sc, addr, wdata, lat, rdata, bus_on);
        #1;
        stalls = stall_o ? 1 : 0;
        cyc    = 0;
        seen   = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (done_o) seen = 1'b1;
            else if (stall_o) stalls++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done_o expected done within 50 cycles", name);
            void'(exp_done.pop_back());
        end else begin
            chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
            chk({name, "_stall_cycles"}, 64'(stalls), 64'(exp_cyc));
            chk({name, "_stall_at_done"}, 64'(stall_o), 64'd0);
        end
        op_valid = 1'b0;
    endtask

    task automatic pulse_snoop(input logic [31:0] addr);
        @(negedge clk);
        snp_we_man   = 1'b1;
        snp_addr_man = addr;
        @(negedge clk);
        snp_we_man = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({name, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({name, "_done"}, 64'(done_o), 64'd0);
        chk({name, "_result"}, 64'(result_o), 64'd0);
        chk({name, "_llbit_we"}, 64'(llbit_we_o), 64'd0);
        chk({name, "_llbit"}, 64'(llbit_o), 64'd0);
        chk({name, "_stall"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        mem_ack = 1'b0; mem_rdata = '0;
        rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_ll = 1'b0; op_sc = 1'b0;
        op_addr = '0; op_wdata = '0;
        llbit_i = 1'b1; wb_llbit_we = 1'b0; wb_llbit_val = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // LL, then successful SC, then a repeat SC that must fail without bus traffic.
        do_op("ll_100", 1, 0, 32'h100, 32'h0, 3, 32'h1111_2222, 32'h1111_2222, 1, 1, 1, 4);
        do_op("sc_100", 0, 1, 32'h100, 32'hDEAD_BEEF, 2, 32'h0, 32'h1, 1, 0, 1, 3);
        do_op("sc_100_again", 0, 1, 32'h100, 32'h5555_AAAA, 1, 32'h0, 32'h0, 0, 0, 0, 1);

        // Unaligned LL forces word address; SC to other word fails; WB forwarding both ways.
        do_op("ll_103", 1, 0, 32'h103, 32'h0, 1, 32'hA5A5_0001, 32'hA5A5_0001, 1, 1, 1, 2);
        do_op("sc_104", 0, 1, 32'h104, 32'h1234_5678, 1, 32'h0, 32'h0, 0, 0, 0, 1);
        wb_llbit_we = 1'b1; wb_llbit_val = 1'b0;
        do_op("sc_fwd0", 0, 1, 32'h102, 32'h1234_5678, 1, 32'h0, 32'h0, 0, 0, 0, 1);
        llbit_i = 1'b0; wb_llbit_val = 1'b1;
        do_op("sc_fwd1", 0, 1, 32'h101, 32'h0BAD_F00D, 1, 32'h0, 32'h1, 1, 0, 1, 2);
        llbit_i = 1'b1; wb_llbit_we = 1'b0;

        // Snoop to the linked word kills the link; a different word does not.
        do_op("ll_200a", 1, 0, 32'h200, 32'h0, 2, 32'h0000_0200, 32'h0000_0200, 1, 1, 1, 3);
        pulse_snoop(32'h202);
        do_op("sc_200_snooped", 0, 1, 32'h200, 32'h7777_7777, 1, 32'h0, 32'h0, 0, 0, 0, 1);
        do_op("ll_200b", 1, 0, 32'h200, 32'h0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 2);
        pulse_snoop(32'h204);
        do_op("sc_200_ok", 0, 1, 32'h200, 32'h8888_8888, 1, 32'h0, 32'h1, 1, 0, 1, 2);

        // op_ll and op_sc both set acts as LL; a snoop coincident with the ack loses.
        do_op("ll_300", 1, 0, 32'h300, 32'h0, 1, 32'h0000_0300, 32'h0000_0300, 1, 1, 1, 2);
        snoop_at_ack   = 1'b1;
        snoop_ack_addr = 32'h300;
        do_op("llsc_300", 1, 1, 32'h300, 32'h9999_9999, 2, 32'hC0DE_0003, 32'hC0DE_0003,
              1, 1, 1, 3);
        do_op("sc_300_ok", 0, 1, 32'h300, 32'h3030_3030, 1, 32'h0, 32'h1, 1, 0, 1, 2);

        // Flush mid-LL: request drops, no completion, link cleared.
        do_op("ll_300b", 1, 0, 32'h300, 32'h0, 1, 32'h0000_3003, 32'h0000_3003, 1, 1, 1, 2);
        start_op(1, 0, 32'h300, 32'h0, 100, 32'h0, 1);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_mem_req", 64'(mem_req), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        exp_bus.delete();
        repeat (3) @(negedge clk);
        do_op("sc_300_flushed", 0, 1, 32'h300, 32'h4444_4444, 1, 32'h0, 32'h0, 0, 0, 0, 1);

        // Reset while an SC waits on the bus.
        do_op("ll_400", 1, 0, 32'h400, 32'h0, 1, 32'h0400_0400, 32'h0400_0400, 1, 1, 1, 2);
        start_op(0, 1, 32'h400, 32'hCAFE_F00D, 100, 32'h0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("sc_req_pending", 64'(mem_req), 64'd1);
        rst = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        check_all_zero("rst_in_sc");
        rst = 1'b0;
        exp_bus.delete();
        do_op("sc_400_after_rst", 0, 1, 32'h400, 32'h1, 1, 32'h0, 32'h0, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        chk("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/llsc_mem_ctrl.md
# llsc_mem_ctrl

MEM-stage load-linked / store-conditional sequencer for the pipeline. It is the consumer side of the LLbit register: it reads the current LLbit, forwards a pending WB-stage LLbit write, and tracks a link address. It issues the LL load or SC store on the data bus with a req/ack handshake and stalls the pipeline while waiting. On completion it produces the value written back to rt and the LLbit write request.

## Interface
- ADDR_W, 32, byte address width; must be ≥ 3
- DATA_W, 32, data width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  exception/pipeline flush; highest priority after rst
- op_valid  in  1  MEM-stage instruction is LL or SC; op fields are held stable while stall_o=1
- op_ll  in  1  instruction is LL (LL wins if op_ll and op_sc are both 1)
- op_sc  in  1  instruction is SC
- op_addr  in  ADDR_W  effective address
- op_wdata  in  DATA_W  SC store data
- llbit_i  in  1  current LLbit register value
- wb_llbit_we  in  1  LLbit write pending in WB
- wb_llbit_val  in  1  value of that pending write
- snoop_we  in  1  a store from another master committed this cycle
- snoop_addr  in  ADDR_W  address of that store
- mem_req  out  1  bus request; held until mem_ack
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  word address; bits [1:0] are forced to 0
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  bus completion; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  load data
- stall_o  out  1  freeze IF–MEM stages
- done_o  out  1  one-cycle completion pulse
- result_o  out  DATA_W  rt writeback value; valid when done_o=1
- llbit_we_o  out  1  LLbit write enable to WB; valid when done_o=1
- llbit_o  out  1  LLbit write value

## Operation
- **Internal state:** FSM states IDLE, LL_REQ, SC_REQ, RESP, plus registers link_valid and link_addr[ADDR_W-1:2].
- **Effective LLbit:** eff = wb_llbit_we ? wb_llbit_val : llbit_i.
- **SC success condition:** sc_ok = eff & link_valid & (link_addr == op_addr[ADDR_W-1:2]).
- **IDLE, op_valid & op_ll:** go to LL_REQ. Register mem_req=1, mem_we=0, mem_addr.
- **IDLE, op_valid & op_sc & sc_ok:** go to SC_REQ. Register mem_req=1, mem_we=1, mem_addr, mem_wdata=op_wdata.
- **IDLE, op_valid & op_sc & !sc_ok:** go to RESP with result 0 and llbit_we_o=0. No bus access.
- **LL_REQ on mem_ack:**
  - mem_req←0.
  - result←mem_rdata; llbit_we_o=1, llbit_o=1.
  - link_addr←word address; link_valid←1.
  - Go to RESP.
- **SC_REQ on mem_ack:**
  - mem_req←0.
  - result←1; llbit_we_o=1, llbit_o=0.
  - link_valid←0.
  - Go to RESP.
- **RESP:** done_o=1 and stall_o=0; go to IDLE. A new op is accepted only in IDLE, so the completing op is never re-accepted.
- **Snoop:** if snoop_we & link_valid & word match in IDLE or LL_REQ, link_valid←0.
  - If it coincides with the LL ack, the LL's link set wins, because the snooped store is ordered before the load data.
  - Snoop is ignored in SC_REQ: the store is already committed to the bus.
- **stall_o:** combinational. stall_o = (state==LL_REQ) | (state==SC_REQ) | (state==IDLE & op_valid).
- **flush:**
  - Any state goes to IDLE.
  - mem_req←0, link_valid←0.
  - done_o, llbit_we_o and result are not produced.
  - If mem_ack arrives in the flush cycle, the bus transfer is considered performed and its result is discarded.
  - Dropping mem_req without ack aborts the bus transaction; the bus guarantees this.
- **rst:** takes priority over flush.
  - state IDLE.
  - mem_req, mem_we, done_o, llbit_we_o, llbit_o, stall_o = 0.
  - mem_addr, mem_wdata, result_o, link_addr = 0; link_valid = 0.

## Timing
- Registered outputs: mem_*, result_o, done_o, llbit_we_o, llbit_o. stall_o is combinational from state and op_valid.
- **LL/successful SC:**
  - Accept at cycle T; mem_req is high from T+1.
  - mem_ack at T+k (k ≥ 1) → done_o at T+k+1.
  - Stall spans T..T+k.
- **Failed SC:** accept at T, done_o at T+1, stall_o high only at T.
- **Forwarding:** the WB forward is sampled in the accept cycle only.
- **Back-to-back ops:** the minimum issue interval is 2 cycles (IDLE, RESP).

## Test plan
- After rst: every output is 0. LL at addr 0x100 with ack 3 cycles after req → done_o with result_o=mem_rdata, llbit_we_o=1, llbit_o=1, stall_o high for 4 cycles.
- LL 0x100, then SC 0x100 data 0xDEADBEEF with llbit_i=1 → store on bus, result_o=1, llbit_o=0, link_valid cleared. A second SC 0x100 → result_o=0 with no mem_req.
- SC 0x104 after LL 0x100 → result_o=0, no bus access. SC with llbit_i=1 but wb_llbit_we=1, wb_llbit_val=0 → result_o=0.
- LL 0x200, then snoop_we to 0x202 (same word) → link_valid=0 and a later SC fails. Snoop to 0x204 → SC succeeds.
- flush during LL_REQ → mem_req drops next cycle, no done_o, link_valid=0. rst asserted in SC_REQ → IDLE with all outputs 0.
- op_ll=op_sc=1 → treated as LL. Snoop coinciding with LL ack → link set.
